// File: rtl/mul_pkg.sv
// Shared types and helpers for the RV32M multicycle multiply unit.
package mul_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PLEN = 64;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } funct3_e;

    typedef enum logic [1:0] {
        MULOP_SS = 2'd1,
        MULOP_SU = 2'd2,
        MULOP_UU = 2'd3
    } mulop_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        mulop_e          mulop;
        logic [PLEN-1:0] p;
    } cache_entry_t;

    // MUL only needs the low word, so any signedness mode works; SS is used.
    function automatic mulop_e funct3_to_mulop(input logic [2:0] f3);
        case (f3)
            F3_MULHSU: return MULOP_SU;
            F3_MULHU:  return MULOP_UU;
            default:   return MULOP_SS;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] select_word(input logic [2:0] f3,
                                                    input logic [PLEN-1:0] p);
        return (f3 == F3_MUL) ? p[XLEN-1:0] : p[PLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_if.sv
// Request/response bundle between EX and the multiply unit.
interface mul_if;

    logic                      start_i;
    logic [2:0]                funct3_i;
    logic [mul_pkg::XLEN-1:0]  rs1_i;
    logic [mul_pkg::XLEN-1:0]  rs2_i;
    logic                      flush_i;
    logic                      busy_o;
    logic                      done_o;
    logic [mul_pkg::XLEN-1:0]  result_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/wallace_mul.sv
// Combinational 32x32 -> 64 multiplier with per-operand signedness (SS/SU/UU).
module wallace_mul
    import mul_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  mulop_e          mulop_i,
    output logic [PLEN-1:0] p_o
);

    logic            a_sx;
    logic            b_sx;
    logic [PLEN-1:0] a_ext;
    logic [PLEN-1:0] b_ext;

    // Low 64 bits of the product of the extended operands are exact for all modes.
    always_comb begin
        a_sx  = (mulop_i != MULOP_UU) & a_i[XLEN-1];
        b_sx  = (mulop_i == MULOP_SS) & b_i[XLEN-1];
        a_ext = {{(PLEN-XLEN){a_sx}}, a_i};
        b_ext = {{(PLEN-XLEN){b_sx}}, b_i};
        p_o   = a_ext * b_ext;
    end

endmodule

// File: rtl/mul_unit.sv
// Multicycle RV32M multiply unit: holds operands LATENCY cycles across wallace_mul,
// with a one-entry product cache so MULH*/MUL pairs on equal operands finish in one cycle.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    mul_if.slave  bus
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      f3_q, f3_d;
    mulop_e          mulop_q, mulop_d;
    logic            cache_valid_q, cache_valid_d;
    cache_entry_t    cache_q, cache_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [PLEN-1:0] prod;
    mulop_e          req_mulop;
    logic            accept;
    logic            hit;

    // Tree sees only registered operands, so the multicycle path is clean.
    wallace_mul u_wallace_mul (
        .a_i     (a_q),
        .b_i     (b_q),
        .mulop_i (mulop_q),
        .p_o     (prod)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        f3_d          = f3_q;
        mulop_d       = mulop_q;
        cache_valid_d = cache_valid_q;
        cache_d       = cache_q;
        result_d      = result_q;

        req_mulop = funct3_to_mulop(bus.funct3_i);
        accept    = bus.start_i & ~bus.flush_i & ~bus.funct3_i[2];
        hit       = cache_valid_q
                    && (bus.rs1_i == cache_q.a)
                    && (bus.rs2_i == cache_q.b)
                    && ((bus.funct3_i == F3_MUL) || (req_mulop == cache_q.mulop));

        case (state_q)
            // DONE accepts like IDLE so back-to-back ops issue without a bubble.
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    a_d     = bus.rs1_i;
                    b_d     = bus.rs2_i;
                    f3_d    = bus.funct3_i;
                    mulop_d = req_mulop;
                    if (hit) begin
                        state_d  = DONE;
                        result_d = select_word(bus.funct3_i, cache_q.p);
                    end else begin
                        state_d = CALC;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    cache_d.a     = a_q;
                    cache_d.b     = b_q;
                    cache_d.mulop = mulop_q;
                    cache_d.p     = prod;
                    cache_valid_d = 1'b1;
                    result_d      = select_word(f3_q, prod);
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            f3_q          <= '0;
            mulop_q       <= MULOP_SS;
            cache_valid_q <= 1'b0;
            cache_q.a     <= '0;
            cache_q.b     <= '0;
            cache_q.mulop <= MULOP_SS;
            cache_q.p     <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            f3_q          <= f3_d;
            mulop_q       <= mulop_d;
            cache_valid_q <= cache_valid_d;
            cache_q       <= cache_d;
            result_q      <= result_d;
        end
    end

    assign bus.busy_o   = (state_q == CALC);
    assign bus.done_o   = (state_q == DONE) & ~bus.flush_i;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit with LATENCY=2.
module tb_mul_unit;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_if bus();

    mul_unit #(.LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single cycle; lat is the cycle (from accept edge) done_o was seen, -1 on timeout.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
        bus.start_i  = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        tick();
        bus.start_i = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 00000000", bus.result_o); end
    endtask

    task automatic test_mul_basic;
        int lat, bc;
        issue(F3_MUL, 32'd7, 32'hFFFFFFFD, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mul_latency: got %0d want 3", lat); end
        n_cmp++; if (bc !== 2) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d want 2", bc); end
        n_cmp++; if (bus.result_o !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result: got %h want ffffffeb", bus.result_o); end
        tick();
        #1;
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL mul_idle_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.result_o !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mul_result_hold: got %h want ffffffeb", bus.result_o); end
    endtask

    task automatic test_cache_hit;
        int lat, bc;
        issue(F3_MULH, 32'h80000000, 32'h80000000, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mulh_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'h40000000) begin n_bad++; $display("FAIL mulh_result: got %h want 40000000", bus.result_o); end
        issue(F3_MUL, 32'h80000000, 32'h80000000, lat, bc);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL hit_latency: got %0d want 1", lat); end
        n_cmp++; if (bc !== 0) begin n_bad++; $display("FAIL hit_busy_cycles: got %0d want 0", bc); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL hit_result: got %h want 00000000", bus.result_o); end
    endtask

    task automatic test_mulop_miss;
        int lat, bc;
        issue(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mulhu_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mulhu_result: got %h want fffffffe", bus.result_o); end
        issue(F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mulop_miss_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL mulop_miss_result: got %h want 00000000", bus.result_o); end
    endtask

    task automatic test_mulhsu;
        int lat, bc;
        issue(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mulhsu_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mulhsu_result: got %h want ffffffff", bus.result_o); end
        issue(F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL su_hit_latency: got %0d want 1", lat); end
        n_cmp++; if (bus.result_o !== 32'h1) begin n_bad++; $display("FAIL su_hit_result: got %h want 00000001", bus.result_o); end
    endtask

    task automatic test_flush;
        int lat, bc;
        bus.start_i  = 1'b1;
        bus.funct3_i = F3_MUL;
        bus.rs1_i    = 32'd3;
        bus.rs2_i    = 32'd5;
        tick();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL flush_calc_busy: got %b want 1", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL flush_calc_done: got %b want 0", bus.done_o); end
        tick();
        bus.flush_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.result_o !== 32'h1) begin n_bad++; $display("FAIL flush_result_hold: got %h want 00000001", bus.result_o); end
        issue(F3_MUL, 32'd3, 32'd5, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL reissue_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'h0000000F) begin n_bad++; $display("FAIL reissue_result: got %h want 0000000f", bus.result_o); end
        // Flush together with start in the DONE cycle: no done, no accept.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL flush_done_mask: got %b want 0", bus.done_o); end
        tick();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL flush_start_done: got %b want 0", bus.done_o); end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        bus.start_i  = 1'b1;
        bus.funct3_i = F3_MUL;
        bus.rs1_i    = 32'd9;
        bus.rs2_i    = 32'd9;
        tick();
        bus.start_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.result_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_result: got %h want 00000000", bus.result_o); end
        issue(F3_MUL, 32'd3, 32'd5, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rstmid_miss_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'h0000000F) begin n_bad++; $display("FAIL rstmid_miss_result: got %h want 0000000f", bus.result_o); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(F3_MUL, 32'd2, 32'd3, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.result_o !== 32'h6) begin n_bad++; $display("FAIL b2b_first_result: got %h want 00000006", bus.result_o); end
        issue(F3_MULHU, 32'hFFFFFFFF, 32'd2, lat, bc);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 3", lat); end
        n_cmp++; if (bc !== 2) begin n_bad++; $display("FAIL b2b_second_busy: got %0d want 2", bc); end
        n_cmp++; if (bus.result_o !== 32'h1) begin n_bad++; $display("FAIL b2b_second_result: got %h want 00000001", bus.result_o); end
        tick();
        #1;
        n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse: got %b want 0", bus.done_o); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.rs1_i    = 32'h0;
        bus.rs2_i    = 32'h0;
        bus.flush_i  = 1'b0;
        test_reset();
        test_mul_basic();
        test_cache_hit();
        test_mulop_miss();
        test_mulhsu();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
